// File: rtl/iq_issue_scheduler.sv
// iq_issue_scheduler: one-entry issue register between the instruction queue
// and execute, with a 32-entry RAW/WAW scoreboard and an in-flight writer limit.
// Optional stall statistics are compiled in when IQ_SCHED_STATS_EN is defined.
module iq_issue_scheduler #(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [74:0]      instr_in,
    output logic             in_ready,
    output logic             out_valid,
    output logic [74:0]      instr_out,
    input  logic             out_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_dest,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] inflight
`ifdef IQ_SCHED_STATS_EN
    ,
    output logic [15:0]      stall_hazard_cnt,
    output logic [15:0]      stall_credit_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e            state_q, state_d;
    logic [74:0]       instr_q, instr_d;
    logic [31:0]       busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0] src1_c, src2_c, dest_c, held_dest_c;
    logic       hazard_c, credit_ok_c, wb_clr_c, flush_clr_c, accept_c, inc_c;
    logic [1:0] dec_c;

    assign src1_c      = instr_in[70:66];
    assign src2_c      = instr_in[65:61];
    assign dest_c      = instr_in[58:54];
    assign held_dest_c = instr_q[58:54];

    // Hazard, credit and ready decode with same-cycle writeback bypass.
    always_comb begin
        hazard_c = 1'b0;
        if (busy_q[src1_c] && !(wb_valid && wb_dest == src1_c)) hazard_c = 1'b1;
        if (busy_q[src2_c] && !(wb_valid && wb_dest == src2_c)) hazard_c = 1'b1;
        if (busy_q[dest_c] && !(wb_valid && wb_dest == dest_c)) hazard_c = 1'b1;
        wb_clr_c    = wb_valid && busy_q[wb_dest];
        credit_ok_c = (cnt_q < MAX_C) || (dest_c == 5'd0) || wb_clr_c;
        in_ready    = !flush && !hazard_c && ((state_q == EMPTY) || out_ready) && credit_ok_c;
        accept_c    = in_valid && in_ready;
    end

    // Next-state: FSM, issue register, scoreboard and in-flight count.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        busy_d      = busy_q;
        inc_c       = 1'b0;
        dec_c       = 2'd0;
        flush_clr_c = 1'b0;

        if (flush) begin
            state_d = EMPTY;
        end else if (accept_c) begin
            state_d = FULL;
            instr_d = instr_in;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end

        if (wb_clr_c) begin
            busy_d[wb_dest] = 1'b0;
            dec_c           = dec_c + 2'd1;
        end

        // A flushed instruction never writes back, so release its destination
        // here unless the writeback above already did.
        flush_clr_c = flush && (state_q == FULL) && busy_q[held_dest_c]
                      && !(wb_clr_c && (wb_dest == held_dest_c));
        if (flush_clr_c) begin
            busy_d[held_dest_c] = 1'b0;
            dec_c               = dec_c + 2'd1;
        end

        // Set after clear so a same-cycle set wins.
        if (accept_c && dest_c != 5'd0) begin
            busy_d[dest_c] = 1'b1;
            inc_c          = 1'b1;
        end

        busy_d[0] = 1'b0;
        cnt_d     = cnt_q + CNT_W'(inc_c) - CNT_W'(dec_c);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            instr_q <= '0;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign instr_out = instr_q;
    assign busy_vec  = busy_q;
    assign inflight  = cnt_q;

`ifdef IQ_SCHED_STATS_EN
    logic [15:0] hz_cnt_q, cr_cnt_q;

    // Saturating stall counters; hazard takes precedence over credit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hz_cnt_q <= '0;
            cr_cnt_q <= '0;
        end else if (in_valid && !in_ready) begin
            if (hazard_c) begin
                if (hz_cnt_q != 16'hFFFF) hz_cnt_q <= hz_cnt_q + 16'd1;
            end else if (!credit_ok_c) begin
                if (cr_cnt_q != 16'hFFFF) cr_cnt_q <= cr_cnt_q + 16'd1;
            end
        end
    end

    assign stall_hazard_cnt = hz_cnt_q;
    assign stall_credit_cnt = cr_cnt_q;
`else
    // Statistics disabled: no extra ports or state.
`endif

endmodule

// File: doc/iq_issue_scheduler.md
Name: iq_issue_scheduler

Overview:
- Issue controller between the instruction queue output and the execute stage.
- Holds each dequeued instruction in a one-entry issue register and tracks a 32-entry register scoreboard (RAW/WAW).
- Limits in-flight writers to MAX_INFLIGHT; releases scoreboard bits on writeback.
- Drives the queue's stall (in_ready low) whenever an instruction cannot issue.

Parameters:
- MAX_INFLIGHT, 8: max issued-but-not-written-back instructions with non-zero Destination; 1..15.
- CNT_W, 4: width of in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  queue presents an instruction.
- instr_in  in  75  packed instruction: [74:71] MajorOpcode, [70:66] Source1, [65:61] Source2, [60:59] OffsetScale, [58:54] Destination, [53:50] MinorOpcode, [49] HasAddress, [48:1] Address, [0] OffsetSub.
- in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready; low = stall to queue.
- out_valid  out  1  issue register holds an instruction.
- instr_out  out  75  issue register contents, same layout.
- out_ready  in  1  execute stage consumes when out_valid&&out_ready.
- wb_valid  in  1  writeback event.
- wb_dest  in  5  register being written back.
- flush  in  1  discard issue register contents.
- busy_vec  out  32  scoreboard; bit 0 always 0.
- inflight  out  CNT_W  current in-flight writer count.

Behaviour:
- Reset (async, immediate): out_valid=0, instr_out=0, busy_vec=0, inflight=0, state=EMPTY. Reset mid-transfer drops the held instruction, clears the scoreboard and aborts all tracking.
- FSM: EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on consume without accept.
  - FULL->FULL on consume+accept (back-to-back, zero bubble) or on no consume.
  - Any->EMPTY on flush (flush takes priority; no accept that cycle).
- Register 0 is never busy; Source/Destination 0 never causes a hazard and never sets a bit.
- Effective busy(r) = busy_vec[r] && !(wb_valid && wb_dest==r): same-cycle writeback bypass.
- hazard = busy(Source1) | busy(Source2) | busy(Destination).
- in_ready = !flush && !hazard && (state==EMPTY || out_ready) && (inflight<MAX_INFLIGHT || Destination==0 || wb frees a slot this cycle). Purely combinational from current inputs/state; no internal registering of ready.
- Accept: instr_out<=instr_in next edge (latency 1 cycle to out_valid); busy_vec[Destination]<=1 if Destination!=0; inflight++.
- Writeback: if wb_valid and busy_vec[wb_dest]: clear bit, inflight--. Writeback to a non-busy or zero register is ignored.
- Same register set and cleared in one cycle: set wins. Simultaneous increment and decrement: inflight unchanged.
- Flush while FULL: held instruction dropped; its Destination bit cleared and inflight-- (it never executes). Flush while EMPTY: no effect. Flush+wb to the same register: cleared once, inflight decremented once.
- inflight never wraps: saturation is impossible by the in_ready rule; underflow is blocked by the busy-bit check.
- instr_out holds its value while FULL and not consumed; its value is undefined-but-stable when EMPTY (last value retained).

Optional Feature:
- Macro IQ_SCHED_STATS_EN.
- Defined: adds outputs stall_hazard_cnt[15:0] and stall_credit_cnt[15:0]. These are saturating counters of cycles where in_valid=1 and in_ready=0, caused respectively by hazard or by the inflight limit (hazard takes precedence when both apply). Reset to 0; hold at 16'hFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then issue Dest=3,Src1=1,Src2=2 with out_ready=1 -> out_valid=1 next cycle, busy_vec=32'h8, inflight=1.
- With r3 busy, present Src1=3 -> in_ready=0 until wb_valid=1,wb_dest=3; that same cycle in_ready=1 (bypass), busy_vec bit3 set again by the new Dest.
- Issue 8 instructions with Dest=1..8, no wb -> 9th with Dest=9 sees in_ready=0, inflight=8; Dest=0 instruction still issues.
- out_ready=0 while FULL -> instr_out stable, in_ready=0; raise out_ready with new in_valid -> back-to-back issue, no bubble.
- FULL holding Dest=5, assert flush -> out_valid=0, busy_vec bit5=0, inflight decremented; wb_dest=5 afterward is ignored.
- Assert reset asynchronously mid-FULL -> out_valid, busy_vec, inflight are 0 immediately, before the next clk edge.
